// File: rtl/ps_ureg_xfer_ctl.sv
// Universal-register transfer controller: decodes ureg source/destination addresses into
// XB/DG/PS register-file ports, with a stallable/flushable write-back pipeline and RAW hazard check.
module ps_ureg_xfer_ctl #(
   parameter int              UA_W    = 8,
   parameter int              XB_W    = 4,
   parameter int              RA_W    = 5,
   parameter int              WB_LAT  = 1,
   parameter logic [3:0]      GRP_XB  = 4'h0,
   parameter logic [3:0]      GRP_DG0 = 4'h1,
   parameter logic [3:0]      GRP_DG1 = 4'h2,
   parameter logic [3:0]      GRP_PS0 = 4'h6,
   parameter logic [3:0]      GRP_PS1 = 4'h7,
   parameter logic [RA_W-1:0] STK_ADD = 5'b00100
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ps_pshstck,
   input  logic            ps_popstck,
   input  logic            ps_imminst,
   input  logic            ps_dminst,
   input  logic            ps_dm_wrb,
   input  logic            ps_urgtrnsinst,
   input  logic [UA_W-1:0] ps_ureg1_add,
   input  logic [UA_W-1:0] ps_ureg2_add,
   input  logic            ps_stall,
   input  logic            ps_flush,
   output logic [XB_W-1:0] ps_xb_dm_rd_add,
   output logic [RA_W-1:0] ps_dg_rd_add,
   output logic [RA_W-1:0] ps_rd_add,
   output logic [XB_W-1:0] ps_xb_dm_wrt_add,
   output logic [RA_W-1:0] ps_dg_wrt_add,
   output logic [RA_W-1:0] ps_wrt_add,
   output logic            ps_xb_w_bcEn,
   output logic            ps_dg_wrt_en,
   output logic            ps_wrt_en,
   output logic            ps_raw_hzd,
   output logic            ps_ureg_err
);

   localparam int AW   = (XB_W > RA_W) ? XB_W : RA_W;
   localparam int LAST = WB_LAT - 1;

   typedef enum logic [1:0] {TGT_NONE, TGT_XB, TGT_DG, TGT_PS} tgt_t;

   function automatic tgt_t grp_tgt(input logic [UA_W-1:0] ureg);
      logic [3:0] grp;
      grp = ureg[UA_W-1 -: 4];
      if (grp == GRP_XB)                         return TGT_XB;
      else if (grp == GRP_DG0 || grp == GRP_DG1) return TGT_DG;
      else if (grp == GRP_PS0 || grp == GRP_PS1) return TGT_PS;
      else                                       return TGT_NONE;
   endfunction

   // XB registers are narrower, so the address field width depends on the target file
   function automatic logic [AW-1:0] tgt_add(input tgt_t tgt, input logic [UA_W-1:0] ureg);
      if (tgt == TGT_XB)      return AW'(ureg[XB_W-1:0]);
      else if (tgt != TGT_NONE) return AW'(ureg[RA_W-1:0]);
      else                    return '0;
   endfunction

   tgt_t          rd_tgt, wr_tgt;
   logic [AW-1:0] rd_add, wr_add;
   logic          rd_err, wr_err;

   always_comb begin
      rd_tgt = TGT_NONE;
      rd_add = '0;
      rd_err = 1'b0;
      if (ps_pshstck || (ps_dminst && ps_dm_wrb)) begin
         rd_tgt = grp_tgt(ps_ureg1_add);
         rd_add = tgt_add(rd_tgt, ps_ureg1_add);
         rd_err = (rd_tgt == TGT_NONE);
      end else if (ps_urgtrnsinst) begin
         rd_tgt = grp_tgt(ps_ureg2_add);
         rd_add = tgt_add(rd_tgt, ps_ureg2_add);
         rd_err = (rd_tgt == TGT_NONE);
      end else if (ps_popstck) begin
         rd_tgt = TGT_PS;
         rd_add = AW'(STK_ADD);
      end
   end

   always_comb begin
      wr_tgt = TGT_NONE;
      wr_add = '0;
      wr_err = 1'b0;
      if (ps_popstck || ps_imminst || ps_urgtrnsinst || (ps_dminst && !ps_dm_wrb)) begin
         wr_tgt = grp_tgt(ps_ureg1_add);
         wr_add = tgt_add(wr_tgt, ps_ureg1_add);
         wr_err = (wr_tgt == TGT_NONE);
      end else if (ps_pshstck) begin
         wr_tgt = TGT_PS;
         wr_add = AW'(STK_ADD);
      end
   end

   assign ps_xb_dm_rd_add = (rd_tgt == TGT_XB) ? rd_add[XB_W-1:0] : '0;
   assign ps_dg_rd_add    = (rd_tgt == TGT_DG) ? rd_add[RA_W-1:0] : '0;
   assign ps_rd_add       = (rd_tgt == TGT_PS) ? rd_add[RA_W-1:0] : '0;

   logic          stg_vld [WB_LAT];
   tgt_t          stg_tgt [WB_LAT];
   logic [AW-1:0] stg_add [WB_LAT];

   // Flush also drops the write decoded in the same cycle; stall freezes every stage
   always_ff @(posedge clk) begin
      if (rst || ps_flush) begin
         for (int k = 0; k < WB_LAT; k++) begin
            stg_vld[k] <= 1'b0;
            stg_tgt[k] <= TGT_NONE;
            stg_add[k] <= '0;
         end
      end else if (!ps_stall) begin
         stg_vld[0] <= (wr_tgt != TGT_NONE);
         stg_tgt[0] <= wr_tgt;
         stg_add[0] <= wr_add;
         for (int k = 1; k < WB_LAT; k++) begin
            stg_vld[k] <= stg_vld[k-1];
            stg_tgt[k] <= stg_tgt[k-1];
            stg_add[k] <= stg_add[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ps_ureg_err <= 1'b0;
      else     ps_ureg_err <= !ps_stall && (rd_err || wr_err);
   end

   assign ps_xb_w_bcEn     = stg_vld[LAST] && (stg_tgt[LAST] == TGT_XB);
   assign ps_dg_wrt_en     = stg_vld[LAST] && (stg_tgt[LAST] == TGT_DG);
   assign ps_wrt_en        = stg_vld[LAST] && (stg_tgt[LAST] == TGT_PS);
   assign ps_xb_dm_wrt_add = ps_xb_w_bcEn ? stg_add[LAST][XB_W-1:0] : '0;
   assign ps_dg_wrt_add    = ps_dg_wrt_en ? stg_add[LAST][RA_W-1:0] : '0;
   assign ps_wrt_add       = ps_wrt_en    ? stg_add[LAST][RA_W-1:0] : '0;

   always_comb begin
      ps_raw_hzd = 1'b0;
      for (int k = 0; k < WB_LAT; k++) begin
         if (stg_vld[k] && rd_tgt != TGT_NONE && stg_tgt[k] == rd_tgt && stg_add[k] == rd_add)
            ps_raw_hzd = 1'b1;
      end
   end

endmodule

// File: tb/tb_ps_ureg_xfer_ctl.sv
// Directed bench for ps_ureg_xfer_ctl: three instances with WB_LAT = 1, 2, 3 share one stimulus stream.
module tb_ps_ureg_xfer_ctl;

   logic       clk = 1'b0;
   logic       rst;
   logic       pshstck, popstck, imminst, dminst, dm_wrb, urgtrnsinst, stall, flush;
   logic [7:0] ureg1, ureg2;

   logic [3:0] xb_rd_add  [3];
   logic [4:0] dg_rd_add  [3];
   logic [4:0] rd_add     [3];
   logic [3:0] xb_wrt_add [3];
   logic [4:0] dg_wrt_add [3];
   logic [4:0] wrt_add    [3];
   logic       xb_en      [3];
   logic       dg_en      [3];
   logic       wrt_en     [3];
   logic       raw_hzd    [3];
   logic       ureg_err   [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Index g of every output array belongs to the instance with WB_LAT = g+1
   for (genvar g = 0; g < 3; g++) begin : g_dut
      ps_ureg_xfer_ctl #(.WB_LAT(g + 1)) u_dut (
         .clk              (clk),
         .rst              (rst),
         .ps_pshstck       (pshstck),
         .ps_popstck       (popstck),
         .ps_imminst       (imminst),
         .ps_dminst        (dminst),
         .ps_dm_wrb        (dm_wrb),
         .ps_urgtrnsinst   (urgtrnsinst),
         .ps_ureg1_add     (ureg1),
         .ps_ureg2_add     (ureg2),
         .ps_stall         (stall),
         .ps_flush         (flush),
         .ps_xb_dm_rd_add  (xb_rd_add[g]),
         .ps_dg_rd_add     (dg_rd_add[g]),
         .ps_rd_add        (rd_add[g]),
         .ps_xb_dm_wrt_add (xb_wrt_add[g]),
         .ps_dg_wrt_add    (dg_wrt_add[g]),
         .ps_wrt_add       (wrt_add[g]),
         .ps_xb_w_bcEn     (xb_en[g]),
         .ps_dg_wrt_en     (dg_en[g]),
         .ps_wrt_en        (wrt_en[g]),
         .ps_raw_hzd       (raw_hzd[g]),
         .ps_ureg_err      (ureg_err[g])
      );
   end

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic push, input logic pop, input logic imm,
                                input logic dm, input logic wrb, input logic trns,
                                input logic [7:0] u1, input logic [7:0] u2,
                                input logic stl, input logic fls);
      pshstck = push; popstck = pop; imminst = imm; dminst = dm; dm_wrb = wrb;
      urgtrnsinst = trns; ureg1 = u1; ureg2 = u2; stall = stl; flush = fls;
      #1;
   endtask

   task automatic applyIdle();
      applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkQuiet(input string tag);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("%s_wrt_en%0d", tag, i), 8'(wrt_en[i]), 8'h0);
         checkOutput($sformatf("%s_dg_en%0d", tag, i), 8'(dg_en[i]), 8'h0);
         checkOutput($sformatf("%s_xb_en%0d", tag, i), 8'(xb_en[i]), 8'h0);
         checkOutput($sformatf("%s_wrt_add%0d", tag, i), 8'(wrt_add[i]), 8'h0);
         checkOutput($sformatf("%s_dg_add%0d", tag, i), 8'(dg_wrt_add[i]), 8'h0);
         checkOutput($sformatf("%s_xb_add%0d", tag, i), 8'(xb_wrt_add[i]), 8'h0);
         checkOutput($sformatf("%s_err%0d", tag, i), 8'(ureg_err[i]), 8'h0);
      end
   endtask

   initial begin
      rst = 1'b1;
      applyIdle();
      tick();
      tick();
      rst = 1'b0;
      checkQuiet("reset");

      // Immediate write to PS 0x03 appears WB_LAT clocks later in each instance
      applyStimulus(0, 0, 1, 0, 0, 0, 8'h63, 8'h00, 0, 0);
      tick();
      applyIdle();
      checkOutput("imm_l1_wrt_en", 8'(wrt_en[0]), 8'h1);
      checkOutput("imm_l1_wrt_add", 8'(wrt_add[0]), 8'h03);
      checkOutput("imm_l1_dg_en", 8'(dg_en[0]), 8'h0);
      checkOutput("imm_l1_xb_en", 8'(xb_en[0]), 8'h0);
      checkOutput("imm_l1_dg_add", 8'(dg_wrt_add[0]), 8'h0);
      checkOutput("imm_l1_xb_add", 8'(xb_wrt_add[0]), 8'h0);
      checkOutput("imm_l2_early", 8'(wrt_en[1]), 8'h0);
      tick();
      checkOutput("imm_l2_wrt_en", 8'(wrt_en[1]), 8'h1);
      checkOutput("imm_l2_wrt_add", 8'(wrt_add[1]), 8'h03);
      checkOutput("imm_l1_retired", 8'(wrt_en[0]), 8'h0);
      tick();
      checkOutput("imm_l3_wrt_en", 8'(wrt_en[2]), 8'h1);
      checkOutput("imm_l3_wrt_add", 8'(wrt_add[2]), 8'h03);
      tick();

      // Transfer XB 0x7 -> DG 0x15
      applyStimulus(0, 0, 0, 0, 0, 1, 8'h15, 8'h07, 0, 0);
      checkOutput("trns_xb_rd", 8'(xb_rd_add[2]), 8'h07);
      checkOutput("trns_dg_rd", 8'(dg_rd_add[2]), 8'h00);
      checkOutput("trns_ps_rd", 8'(rd_add[2]), 8'h00);
      tick();
      applyIdle();
      tick();
      checkOutput("trns_l3_early", 8'(dg_en[2]), 8'h0);
      checkOutput("trns_l2_dg_en", 8'(dg_en[1]), 8'h1);
      tick();
      checkOutput("trns_l3_dg_en", 8'(dg_en[2]), 8'h1);
      checkOutput("trns_l3_dg_add", 8'(dg_wrt_add[2]), 8'h15);
      checkOutput("trns_l3_ps_en", 8'(wrt_en[2]), 8'h0);
      tick();

      // Push reads DG 0x04 and writes the stack register
      applyStimulus(1, 0, 0, 0, 0, 0, 8'h24, 8'h00, 0, 0);
      checkOutput("push_dg_rd", 8'(dg_rd_add[0]), 8'h04);
      checkOutput("push_xb_rd", 8'(xb_rd_add[0]), 8'h00);
      tick();
      applyIdle();
      checkOutput("push_wrt_en", 8'(wrt_en[0]), 8'h1);
      checkOutput("push_wrt_add", 8'(wrt_add[0]), 8'h04);
      tick();
      tick();
      tick();

      // Pop reads PS stack register
      applyStimulus(0, 1, 0, 0, 0, 0, 8'h63, 8'h00, 0, 0);
      checkOutput("pop_ps_rd", 8'(rd_add[0]), 8'h04);
      applyIdle();
      tick();
      tick();
      tick();
      tick();

      // RAW hazard: write PS 0x12, then DM write reads the same ureg
      applyStimulus(0, 0, 1, 0, 0, 0, 8'h72, 8'h00, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 1, 0, 8'h73, 8'h00, 0, 0);
      checkOutput("hzd_other_addr", 8'(raw_hzd[1]), 8'h0);
      applyStimulus(0, 0, 0, 1, 1, 0, 8'h72, 8'h00, 0, 0);
      checkOutput("hzd_rd_add", 8'(rd_add[1]), 8'h12);
      checkOutput("hzd_stage0", 8'(raw_hzd[1]), 8'h1);
      tick();
      checkOutput("hzd_out_stage", 8'(raw_hzd[1]), 8'h1);
      checkOutput("hzd_wrt_en", 8'(wrt_en[1]), 8'h1);
      tick();
      checkOutput("hzd_retired", 8'(raw_hzd[1]), 8'h0);
      applyIdle();
      tick();
      tick();

      // Stall freezes the pipeline, flush then kills everything in flight
      applyStimulus(0, 0, 1, 0, 0, 0, 8'h63, 8'h00, 0, 0);
      tick();
      applyStimulus(0, 0, 1, 0, 0, 0, 8'h15, 8'h00, 1, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("stall%0d_l1_en", c), 8'(wrt_en[0]), 8'h1);
         checkOutput($sformatf("stall%0d_l1_add", c), 8'(wrt_add[0]), 8'h03);
         checkOutput($sformatf("stall%0d_l1_dg", c), 8'(dg_en[0]), 8'h0);
         checkOutput($sformatf("stall%0d_l2_en", c), 8'(wrt_en[1]), 8'h0);
      end
      applyStimulus(0, 0, 1, 0, 0, 0, 8'h15, 8'h00, 1, 1);
      tick();
      applyIdle();
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("flush%0d_ps_en%0d", c, i), 8'(wrt_en[i]), 8'h0);
            checkOutput($sformatf("flush%0d_dg_en%0d", c, i), 8'(dg_en[i]), 8'h0);
         end
         tick();
      end

      // Illegal destination group 4
      applyStimulus(0, 0, 1, 0, 0, 0, 8'h40, 8'h00, 0, 0);
      tick();
      applyIdle();
      checkOutput("err_pulse", 8'(ureg_err[0]), 8'h1);
      checkOutput("err_no_ps_en", 8'(wrt_en[0]), 8'h0);
      checkOutput("err_no_dg_en", 8'(dg_en[0]), 8'h0);
      checkOutput("err_no_xb_en", 8'(xb_en[0]), 8'h0);
      tick();
      checkOutput("err_one_cycle", 8'(ureg_err[0]), 8'h0);
      checkOutput("err_l2_no_en", 8'(wrt_en[1]), 8'h0);
      applyStimulus(0, 0, 1, 0, 0, 0, 8'h40, 8'h00, 1, 0);
      tick();
      checkOutput("err_stall_suppr", 8'(ureg_err[0]), 8'h0);
      applyStimulus(0, 0, 0, 0, 0, 1, 8'h63, 8'h50, 0, 0);
      tick();
      applyIdle();
      checkOutput("err_read_side", 8'(ureg_err[2]), 8'h1);
      tick();
      tick();
      tick();

      // Reset mid-pipeline discards pending writes
      applyStimulus(0, 0, 1, 0, 0, 0, 8'h63, 8'h00, 0, 0);
      tick();
      applyStimulus(0, 0, 1, 0, 0, 0, 8'h15, 8'h00, 0, 0);
      tick();
      rst = 1'b1;
      applyIdle();
      tick();
      checkQuiet("rst_mid");
      rst = 1'b0;
      tick();
      checkQuiet("rst_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps_ureg_xfer_ctl.md
Name: ps_ureg_xfer_ctl

Overview:
- Parametrised successor to the universal-register (ureg) address decoder in the program sequencer.
- Decodes ureg source and destination addresses into per-file read/write ports for three register files:
  - XB: data register file via crossbar.
  - DG: DAG registers.
  - PS: sequencer registers.
- Write-back is carried through a configurable-latency pipeline with stall and flush.
- Adds RAW hazard detection against in-flight writes and an illegal-address flag.

Parameters:
- UA_W, 8: ureg address width; group code is bits [UA_W-1:UA_W-4].
- XB_W, 4: XB register address width, taken from ureg bits [XB_W-1:0].
- RA_W, 5: DG/PS register address width, taken from ureg bits [RA_W-1:0].
- WB_LAT, 1: write-back pipeline depth in cycles; legal range 1..4.
- GRP_XB, 4'h0: group code for XB.
- GRP_DG0, 4'h1: first group code for DG.
- GRP_DG1, 4'h2: second group code for DG.
- GRP_PS0, 4'h6: first group code for PS.
- GRP_PS1, 4'h7: second group code for PS.
- STK_ADD, 5'b00100: PS address of the stack register used by push/pop.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ps_pshstck  in  1  push-stack instruction.
- ps_popstck  in  1  pop-stack instruction.
- ps_imminst  in  1  immediate-to-ureg instruction.
- ps_dminst  in  1  data-memory transfer instruction.
- ps_dm_wrb  in  1  DM direction: 1 = memory write (ureg read), 0 = memory read (ureg write).
- ps_urgtrnsinst  in  1  ureg-to-ureg transfer.
- ps_ureg1_add  in  UA_W  destination ureg (source for push and DM write).
- ps_ureg2_add  in  UA_W  source ureg for transfers.
- ps_stall  in  1  freeze write-back pipeline.
- ps_flush  in  1  kill all in-flight writes.
- ps_xb_dm_rd_add  out  XB_W  XB read address.
- ps_dg_rd_add  out  RA_W  DG read address.
- ps_rd_add  out  RA_W  PS read address.
- ps_xb_dm_wrt_add  out  XB_W  XB write address.
- ps_dg_wrt_add  out  RA_W  DG write address.
- ps_wrt_add  out  RA_W  PS write address.
- ps_xb_w_bcEn  out  1  XB write enable.
- ps_dg_wrt_en  out  1  DG write enable.
- ps_wrt_en  out  1  PS write enable.
- ps_raw_hzd  out  1  current read collides with an in-flight write.
- ps_ureg_err  out  1  one-cycle pulse: illegal group code decoded.

Behaviour:

Read side (combinational, zero latency):
- Select the read source, highest priority first:
  - ps_pshstck | (ps_dminst & ps_dm_wrb) → ps_ureg1_add.
  - ps_urgtrnsinst → ps_ureg2_add.
  - ps_popstck → PS at STK_ADD.
  - otherwise → no read.
- Group mapping:
  - GRP_XB drives ps_xb_dm_rd_add.
  - GRP_DG0/1 drives ps_dg_rd_add.
  - GRP_PS0/1 drives ps_rd_add.
- Every read address not selected is 0.

Write side:
- Write request is present when ps_popstck | ps_imminst | ps_urgtrnsinst | (ps_dminst & ~ps_dm_wrb).
  - Target is decoded from ps_ureg1_add using the same group mapping.
- Otherwise, if ps_pshstck: target is PS at STK_ADD.
- Otherwise: no write.
- Each pipeline stage holds {valid, target (XB/DG/PS), address}.
  - Stage 0 captures the decoded write each clock.
  - Stage k captures stage k-1.
  - Outputs are driven from stage WB_LAT-1.
- Latency: write enables and write addresses appear exactly WB_LAT clocks after decode.
- ps_xb_dm_wrt_add is pipelined identically to the DG/PS fields; it is no longer combinational.
- Only the enable matching the output-stage target is 1. All write addresses whose enable is 0 read as 0.

Stall, flush, reset:
- ps_stall=1: all stages hold; new decode is discarded (the upstream holds the instruction); outputs unchanged.
- ps_flush=1: all stages cleared to invalid on the next edge.
  - Flush wins over stall.
  - The write decoded in the flush cycle is also dropped.
- rst=1: all stages invalid; every output 0 on the next edge, including ps_ureg_err.
  - Reset mid-pipeline discards pending writes.

Hazard (combinational):
- ps_raw_hzd=1 when the current read target and address equal those of any valid stage 0..WB_LAT-1, including the output stage.
- The hazard is evaluated during stall.
- A stage with valid=0 never matches.

Error:
- ps_ureg_err is registered and pulses for 1 cycle after a read or write decode whose group code is not GRP_XB, GRP_DG0/1 or GRP_PS0/1.
- No write is queued for an illegal destination.
- Suppressed while ps_stall=1.

Test Plan:
- WB_LAT=1; ps_imminst=1, ps_ureg1_add=8'h63 → next cycle ps_wrt_en=1, ps_wrt_add=5'h03; all other enables and addresses 0.
- WB_LAT=3; ps_urgtrnsinst, ureg1=8'h15, ureg2=8'h07:
  - Same cycle: ps_xb_dm_rd_add=4'h7.
  - 3 cycles later: ps_dg_wrt_en=1, ps_dg_wrt_add=5'h15.
- ps_pshstck, ureg1=8'h24 → same cycle ps_dg_rd_add=5'h04; after WB_LAT cycles ps_wrt_en=1, ps_wrt_add=5'b00100.
- WB_LAT=2; write to 8'h72, then next-cycle DM write (ps_dminst=1, ps_dm_wrb=1) reading 8'h72 → ps_raw_hzd=1; after the write retires, ps_raw_hzd=0.
- WB_LAT=2; queue a write, assert ps_stall 3 cycles → outputs frozen; then ps_flush → no enable ever asserts.
- ps_imminst with ureg1=8'h40 → ps_ureg_err pulses 1 cycle, no write enable; rst asserted mid-pipeline → all outputs 0 next edge.
